baud_clk_div: RTL and testbench



---
 rtl/baud_div_pkg.sv | 13 +
 rtl/div_half_stretch.sv | 32 +++
 rtl/baud_clk_div.sv | 121 ++++++++++++
 tb/tb_baud_clk_div.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/baud_div_pkg.sv
// rtl/baud_div_pkg.sv - shared constants and helpers for the baud clock divider
package baud_div_pkg;

  localparam int DIV_W_DEF      = 16;
  localparam int DIV_MIN        = 2;
  localparam int DIV_DEF_115200 = 434;

  // High-phase length in whole cycles for divisor d (odd divisors add a half cycle downstream)
  function automatic logic [31:0] half_of(input logic [31:0] d);
    return d >> 1;
  endfunction

endpackage

// File: rtl/div_half_stretch.sv
// rtl/div_half_stretch.sv - negedge stretch flop and odd/even output select
module div_half_stretch (
  input  logic clk,
  input  logic rst,
  input  logic clk_p,
  input  logic odd,
  output logic clk_out
);

  logic clk_n_q;
  logic clk_n_d;

  // clk_n trails clk_p by half a cycle
  always_comb begin
    clk_n_d = clk_p;
  end

  // Negedge copy of clk_p, cleared asynchronously with everything else
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      clk_n_q <= 1'b0;
    end else begin
      clk_n_q <= clk_n_d;
    end
  end

  // Odd divisors stretch the high phase by half a cycle; even ones use clk_p directly
  always_comb begin
    clk_out = odd ? (clk_p | clk_n_q) : clk_p;
  end

endmodule

// File: rtl/baud_clk_div.sv
// rtl/baud_clk_div.sv - programmable 50%-duty clock divider with baud tick
module baud_clk_div
  import baud_div_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_DEF = DIV_DEF_115200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  output logic [DIV_W-1:0] div_cur,
  output logic             div_pend,
  output logic             div_err,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEF);
  localparam logic [DIV_W-1:0] DIV_LO  = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_cur_q, div_cur_d;
  logic [DIV_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic             clk_p_q, clk_p_d;
  logic             tick_q, tick_d;
  logic [DIV_W-1:0] half;
  logic             at_end;
  logic             load_ok;

  // Counter, high-phase register, tick and divisor load/apply decisions
  always_comb begin
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    err_d      = err_q;
    clk_p_d    = clk_p_q;
    tick_d     = 1'b0;
    half       = DIV_W'(half_of(32'(div_cur_q)));
    at_end     = (cnt_q == div_cur_q - ONE);
    load_ok    = (div_in >= DIV_LO);

    if (!en) begin
      cnt_d   = '0;
      clk_p_d = 1'b0;
    end else begin
      tick_d = at_end;
      if (at_end) begin
        // Boundary: new period starts high; a pending divisor takes over here
        cnt_d   = '0;
        clk_p_d = 1'b1;
        if (pend_q) begin
          div_cur_d = pend_val_q;
          pend_d    = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + ONE;
        // Set only at a boundary, so the warm-up run after enable stays low
        if (cnt_q + ONE == half) begin
          clk_p_d = 1'b0;
        end
      end
    end

    // A load on a boundary cycle overrides the pending state just consumed above
    if (div_load) begin
      if (!load_ok) begin
        err_d = 1'b1;
      end else begin
        err_d = 1'b0;
        if (en) begin
          pend_val_d = div_in;
          pend_d     = 1'b1;
        end else begin
          div_cur_d = div_in;
          pend_d    = 1'b0;
        end
      end
    end
  end

  // Posedge state with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      div_cur_q  <= DIV_RST;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      clk_p_q    <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      clk_p_q    <= clk_p_d;
      tick_q     <= tick_d;
    end
  end

  div_half_stretch u_stretch (
    .clk     (clk),
    .rst     (rst),
    .clk_p   (clk_p_q),
    .odd     (div_cur_q[0]),
    .clk_out (clk_out)
  );

  assign div_cur  = div_cur_q;
  assign div_pend = pend_q;
  assign div_err  = err_q;
  assign tick     = tick_q;

endmodule

// File: tb/tb_baud_clk_div.sv
// tb/tb_baud_clk_div.sv - directed self-checking bench for baud_clk_div
module tb_baud_clk_div;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] div_in;
  logic        div_load;
  logic [15:0] div_cur;
  logic        div_pend;
  logic        div_err;
  logic        clk_out;
  logic        tick;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] div_in;
    logic        exp_err;
    logic [15:0] exp_cur;
  } vec_t;

  vec_t vecs [0:4];

  baud_clk_div #(.DIV_W(16), .DIV_DEF(434)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_in   (div_in),
    .div_load (div_load),
    .div_cur  (div_cur),
    .div_pend (div_pend),
    .div_err  (div_err),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int val);
    div_in   = 16'(val);
    div_load = 1'b1;
    step();
    div_load = 1'b0;
  endtask

  // Posedges until tick is seen (bounded)
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < 70000);
  endtask

  // Starting at a tick: posedges to the next tick and high half-cycles in between
  task automatic measure(input string name, input int d);
    int per;
    int hi;
    per = 0;
    hi  = 0;
    check({name, "_rise_at_tick"}, int'(clk_out), 1);
    do begin
      hi += int'(clk_out);
      @(negedge clk);
      #1;
      hi += int'(clk_out);
      step();
      per++;
    end while (!tick && per < 70000);
    check({name, "_period"}, per, d);
    check({name, "_high_halves"}, hi, d);
  endtask

  initial begin
    int n;
    int ticks;

    vecs[0] = '{16'd2, 1'b0, 16'd2};
    vecs[1] = '{16'd3, 1'b0, 16'd3};
    vecs[2] = '{16'd1, 1'b1, 16'd3};
    vecs[3] = '{16'd0, 1'b1, 16'd3};
    vecs[4] = '{16'd4, 1'b0, 16'd4};

    rst      = 1'b0;
    en       = 1'b0;
    div_in   = '0;
    div_load = 1'b0;
    step();
    step();
    check("rst_cur", int'(div_cur), 434);
    check("rst_pend", int'(div_pend), 0);
    check("rst_err", int'(div_err), 0);
    check("rst_clk_out", int'(clk_out), 0);
    check("rst_tick", int'(tick), 0);

    // Default divisor from reset release
    en  = 1'b1;
    rst = 1'b1;
    wait_tick(n);
    check("def_first_tick", n, 434);
    measure("def", 434);

    // Divisor table loaded while disabled, then run
    for (int i = 0; i < 5; i++) begin
      en = 1'b0;
      step();
      load(int'(vecs[i].div_in));
      check($sformatf("v%0d_cur", i), int'(div_cur), int'(vecs[i].exp_cur));
      check($sformatf("v%0d_err", i), int'(div_err), int'(vecs[i].exp_err));
      check($sformatf("v%0d_pend", i), int'(div_pend), 0);
      en = 1'b1;
      wait_tick(n);
      check($sformatf("v%0d_first_tick", i), n, int'(vecs[i].exp_cur));
      measure($sformatf("v%0d", i), int'(vecs[i].exp_cur));
    end

    // Running at 4: load 5 mid-period
    step();
    load(5);
    check("d5_pend", int'(div_pend), 1);
    check("d5_cur_old", int'(div_cur), 4);
    wait_tick(n);
    check("d5_boundary", n, 2);
    check("d5_pend_clr", int'(div_pend), 0);
    check("d5_cur", int'(div_cur), 5);
    measure("d5", 5);

    // Illegal loads keep the divisor; next legal load clears the error
    load(1);
    load(0);
    check("bad_err", int'(div_err), 1);
    check("bad_cur", int'(div_cur), 5);
    check("bad_pend", int'(div_pend), 0);
    wait_tick(n);
    check("bad_boundary", n, 3);
    measure("bad", 5);
    load(6);
    check("d6_err", int'(div_err), 0);
    check("d6_pend", int'(div_pend), 1);
    check("d6_cur_old", int'(div_cur), 5);
    wait_tick(n);
    check("d6_boundary", n, 4);
    check("d6_cur", int'(div_cur), 6);
    measure("d6", 6);

    // Move to 8, then two loads in one period: latest wins
    load(8);
    wait_tick(n);
    check("d8_cur", int'(div_cur), 8);
    step();
    load(7);
    load(9);
    check("d9_pend", int'(div_pend), 1);
    wait_tick(n);
    check("d9_boundary", n, 5);
    check("d9_cur", int'(div_cur), 9);
    check("d9_pend_clr", int'(div_pend), 0);

    // Load on the boundary cycle: older pending applies, new one waits a period
    step();
    load(10);
    repeat (6) step();
    check("bnd_pre_tick", int'(tick), 0);
    load(3);
    check("bnd_tick", int'(tick), 1);
    check("bnd_cur", int'(div_cur), 10);
    check("bnd_pend", int'(div_pend), 1);
    measure("bnd10", 10);
    check("bnd_cur3", int'(div_cur), 3);
    check("bnd_pend_clr", int'(div_pend), 0);

    // Asynchronous reset while clk_out is high (held by the negedge flop)
    load(0);
    check("ar_err_pre", int'(div_err), 1);
    check("ar_clk_out_pre", int'(clk_out), 1);
    #1;
    rst = 1'b0;
    #1;
    check("ar_clk_out", int'(clk_out), 0);
    check("ar_tick", int'(tick), 0);
    check("ar_err", int'(div_err), 0);
    check("ar_pend", int'(div_pend), 0);
    check("ar_cur", int'(div_cur), 434);
    step();
    step();
    check("ar_held_clk_out", int'(clk_out), 0);
    rst = 1'b1;
    wait_tick(n);
    check("ar_first_tick", n, 434);

    // Enable dropped mid-period while clk_out is high
    step();
    step();
    check("dis_clk_out_pre", int'(clk_out), 1);
    en = 1'b0;
    step();
    check("dis_tick", int'(tick), 0);
    @(negedge clk);
    #1;
    check("dis_clk_out", int'(clk_out), 0);
    ticks = 0;
    repeat (440) begin
      step();
      ticks += int'(tick) + int'(clk_out);
    end
    check("dis_quiet", ticks, 0);
    en = 1'b1;
    wait_tick(n);
    check("reen_first_tick", n, 434);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
